// File: rtl/daq_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : daq_frame_ctrl
// Brief    : Host-commanded run controller framing 32-bit DAQ words into the
//            read FIFO as header / payload / tailer with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module daq_frame_ctrl #(
   parameter int         WORDS_PER_FRAME = 24,
   parameter int         GAP_CYCLES      = 0,
   parameter logic [7:0] HDR_BYTE        = 8'hF0,
   parameter logic [7:0] TLR_BYTE        = 8'hAA,
   parameter logic [7:0] CMD_START       = 8'hFF,
   parameter logic [7:0] CMD_RESET       = 8'hC0,
   parameter logic [7:0] CMD_CLOSE       = 8'hC7
) (
   input  logic        bus_clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_data,
   input  logic        stream_open,
   input  logic        fifo_full,
   output logic [31:0] fifo_din,
   output logic        fifo_wr_en,
   output logic        fifo_srst,
   output logic        busy,
   output logic [23:0] frame_cnt,
   output logic        led_run
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_PAY  = 3'd2,
      ST_TLR  = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   localparam logic [15:0] c_last_word = 16'(WORDS_PER_FRAME - 1);
   localparam logic [15:0] c_gap_last  = 16'(GAP_CYCLES - 1);

   state_t      r_state, w_state;
   logic [15:0] r_word_idx, w_word_idx;
   logic [15:0] r_xor, w_xor;
   logic [15:0] r_gap_cnt, w_gap_cnt;
   logic [23:0] r_frame_cnt, w_frame_cnt;
   logic [31:0] r_din, w_din;
   logic        r_close_pend, w_close_pend;
   logic        r_srst;
   logic        r_led;
   logic        r_open_q;

   logic w_busy, w_accept;
   logic w_cmd_start, w_cmd_close, w_cmd_reset, w_open_fall, w_abort;

   assign w_busy      = (r_state == ST_HDR) || (r_state == ST_PAY) || (r_state == ST_TLR);
   assign w_accept    = w_busy && !fifo_full;
   assign w_cmd_start = cmd_valid && (cmd_data == CMD_START);
   assign w_cmd_close = cmd_valid && (cmd_data == CMD_CLOSE);
   assign w_cmd_reset = cmd_valid && (cmd_data == CMD_RESET);
   assign w_open_fall = r_open_q && !stream_open;
   assign w_abort     = w_cmd_reset || w_open_fall;

   always_comb begin
      w_state      = r_state;
      w_word_idx   = r_word_idx;
      w_xor        = r_xor;
      w_gap_cnt    = r_gap_cnt;
      w_frame_cnt  = r_frame_cnt;
      w_din        = r_din;
      w_close_pend = r_close_pend;

      if (w_abort) begin
         w_state      = ST_IDLE;
         w_word_idx   = 16'd0;
         w_xor        = 16'd0;
         w_gap_cnt    = 16'd0;
         w_frame_cnt  = 24'd0;
         w_din        = 32'd0;
         w_close_pend = 1'b0;
      end else begin
         if (r_state != ST_IDLE) begin
            if (w_cmd_close)
               w_close_pend = 1'b1;
            else if (w_cmd_start)
               w_close_pend = 1'b0;
         end

         // The next word is loaded together with the state so it is on
         // fifo_din the same cycle the new state can write it.
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_start && stream_open) begin
                  w_state    = ST_HDR;
                  w_word_idx = 16'd0;
                  w_xor      = 16'd0;
                  w_din      = {HDR_BYTE, r_frame_cnt};
               end
            end
            ST_HDR: begin
               if (w_accept) begin
                  w_state = ST_PAY;
                  w_din   = {r_frame_cnt[15:0], 16'd0};
               end
            end
            ST_PAY: begin
               if (w_accept) begin
                  w_xor = r_xor ^ r_word_idx;
                  if (r_word_idx == c_last_word) begin
                     w_state = ST_TLR;
                     w_din   = {TLR_BYTE, 8'h00, r_xor ^ r_word_idx};
                  end else begin
                     w_word_idx = r_word_idx + 16'd1;
                     w_din      = {r_frame_cnt[15:0], r_word_idx + 16'd1};
                  end
               end
            end
            ST_TLR: begin
               if (w_accept) begin
                  w_frame_cnt = r_frame_cnt + 24'd1;
                  if (w_close_pend) begin
                     w_state      = ST_IDLE;
                     w_close_pend = 1'b0;
                     w_din        = 32'd0;
                  end else if (GAP_CYCLES == 0) begin
                     w_state    = ST_HDR;
                     w_word_idx = 16'd0;
                     w_xor      = 16'd0;
                     w_din      = {HDR_BYTE, w_frame_cnt};
                  end else begin
                     w_state   = ST_GAP;
                     w_gap_cnt = 16'd0;
                  end
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == c_gap_last) begin
                  w_state    = ST_HDR;
                  w_word_idx = 16'd0;
                  w_xor      = 16'd0;
                  w_din      = {HDR_BYTE, r_frame_cnt};
               end else begin
                  w_gap_cnt = r_gap_cnt + 16'd1;
               end
            end
            default: begin
               w_state = ST_IDLE;
               w_din   = 32'd0;
            end
         endcase
      end
   end

   always_ff @(posedge bus_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_word_idx   <= 16'd0;
         r_xor        <= 16'd0;
         r_gap_cnt    <= 16'd0;
         r_frame_cnt  <= 24'd0;
         r_din        <= 32'd0;
         r_close_pend <= 1'b0;
         r_srst       <= 1'b1;
         r_led        <= 1'b0;
         r_open_q     <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_word_idx   <= w_word_idx;
         r_xor        <= w_xor;
         r_gap_cnt    <= w_gap_cnt;
         r_frame_cnt  <= w_frame_cnt;
         r_din        <= w_din;
         r_close_pend <= w_close_pend;
         // Stream close aborts like a reset but the FIFO is reset elsewhere.
         r_srst       <= w_cmd_reset;
         r_led        <= (w_state != ST_IDLE);
         r_open_q     <= stream_open;
      end
   end

   assign fifo_din   = r_din;
   assign fifo_wr_en = w_accept;
   assign fifo_srst  = r_srst;
   assign busy       = w_busy;
   assign frame_cnt  = r_frame_cnt;
   assign led_run    = r_led;

endmodule
`default_nettype wire

// File: tb/tb_daq_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_daq_frame_ctrl
// Brief    : Directed self-checking bench for daq_frame_ctrl (4-word frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_daq_frame_ctrl;

   logic        bus_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_data = 8'h00;
   logic        stream_open = 1'b1;
   logic        fifo_full = 1'b0;
   logic [31:0] fifo_din;
   logic        fifo_wr_en;
   logic        fifo_srst;
   logic        busy;
   logic [23:0] frame_cnt;
   logic        led_run;

   int n_cmp  = 0;
   int n_fail = 0;

   daq_frame_ctrl #(
      .WORDS_PER_FRAME(4),
      .GAP_CYCLES     (0)
   ) dut (
      .bus_clk    (bus_clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_data   (cmd_data),
      .stream_open(stream_open),
      .fifo_full  (fifo_full),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_srst  (fifo_srst),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .led_run    (led_run)
   );

   always #5 bus_clk = ~bus_clk;

   task automatic cyc();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [7:0] code);
      cmd_valid = 1'b1;
      cmd_data  = code;
      cyc();
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
   endtask

   initial begin
      logic [31:0] exp_w;

      // Reset values while rst_n is held low
      cyc();
      cyc();
      chk("rst_din",   fifo_din,   32'h0);
      chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      chk("rst_srst",  {31'd0, fifo_srst},  32'd1);
      chk("rst_busy",  {31'd0, busy},       32'd0);
      chk("rst_cnt",   {8'd0, frame_cnt},   32'd0);
      chk("rst_led",   {31'd0, led_run},    32'd0);
      #2 rst_n = 1'b1;
      #1 chk("srst_after_release", {31'd0, fifo_srst}, 32'd1);
      cyc();
      chk("srst_cleared", {31'd0, fifo_srst}, 32'd0);
      cyc();

      // Back-to-back frames: two complete frames then next header
      send_cmd(8'hFF);
      for (int f = 0; f < 2; f++) begin
         for (int w = 0; w < 6; w++) begin
            if (w == 0)      exp_w = {8'hF0, 24'(f)};
            else if (w == 5) exp_w = 32'hAA000000;
            else             exp_w = {16'(f), 16'(w - 1)};
            chk($sformatf("f%0d_w%0d_din", f, w), fifo_din, exp_w);
            chk($sformatf("f%0d_w%0d_wr", f, w), {31'd0, fifo_wr_en}, 32'd1);
            chk($sformatf("f%0d_w%0d_cnt", f, w), {8'd0, frame_cnt}, 32'(f));
            cyc();
         end
      end
      chk("f2_hdr", fifo_din, 32'hF0000002);
      chk("f2_cnt", {8'd0, frame_cnt}, 32'd2);
      chk("f2_led", {31'd0, led_run}, 32'd1);

      // Backpressure on payload word 1 for 10 cycles
      cyc();
      cyc();
      chk("pre_full_din", fifo_din, 32'h00020001);
      fifo_full = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("full%0d_wr", i), {31'd0, fifo_wr_en}, 32'd0);
         chk($sformatf("full%0d_din", i), fifo_din, 32'h00020001);
         chk($sformatf("full%0d_busy", i), {31'd0, busy}, 32'd1);
         cyc();
      end
      fifo_full = 1'b0;
      #1;
      chk("resume_wr",  {31'd0, fifo_wr_en}, 32'd1);
      chk("resume_din", fifo_din, 32'h00020001);
      cyc();
      chk("resume_next", fifo_din, 32'h00020002);

      // Graceful close issued while word 2 is written
      send_cmd(8'hC7);
      chk("close_w3", fifo_din, 32'h00020003);
      cyc();
      chk("close_tlr", fifo_din, 32'hAA000000);
      chk("close_tlr_busy", {31'd0, busy}, 32'd1);
      cyc();
      chk("close_idle_busy", {31'd0, busy}, 32'd0);
      chk("close_idle_led",  {31'd0, led_run}, 32'd0);
      chk("close_idle_wr",   {31'd0, fifo_wr_en}, 32'd0);
      chk("close_cnt",       {8'd0, frame_cnt}, 32'd3);
      cyc();
      chk("close_stays_idle", {31'd0, busy}, 32'd0);

      // Restart, then immediate reset during payload
      send_cmd(8'hFF);
      chk("restart_hdr", fifo_din, 32'hF0000003);
      cyc();
      chk("restart_w0", fifo_din, 32'h00030000);
      send_cmd(8'hC0);
      chk("reset_busy", {31'd0, busy},      32'd0);
      chk("reset_srst", {31'd0, fifo_srst}, 32'd1);
      chk("reset_cnt",  {8'd0, frame_cnt},  32'd0);
      chk("reset_wr",   {31'd0, fifo_wr_en}, 32'd0);
      cyc();
      chk("reset_srst_1cyc", {31'd0, fifo_srst}, 32'd0);
      send_cmd(8'hFF);
      chk("post_reset_hdr", fifo_din, 32'hF0000000);
      chk("post_reset_wr",  {31'd0, fifo_wr_en}, 32'd1);

      // Stream close mid-frame
      cyc();
      chk("open_w0", fifo_din, 32'h00000000);
      stream_open = 1'b0;
      cyc();
      chk("open_drop_busy", {31'd0, busy},      32'd0);
      chk("open_drop_srst", {31'd0, fifo_srst}, 32'd0);
      cyc();
      chk("open_drop_led",  {31'd0, led_run},   32'd0);
      send_cmd(8'hFF);
      cyc();
      chk("start_closed_busy", {31'd0, busy}, 32'd0);
      chk("start_closed_wr",   {31'd0, fifo_wr_en}, 32'd0);
      send_cmd(8'h12);
      chk("unknown_idle", {31'd0, busy}, 32'd0);
      stream_open = 1'b1;
      cyc();
      send_cmd(8'hFF);
      chk("reopen_hdr", fifo_din, 32'hF0000000);
      cyc();
      send_cmd(8'h12);
      chk("unknown_run_din",  fifo_din, 32'h00000001);
      chk("unknown_run_busy", {31'd0, busy}, 32'd1);

      // Asynchronous reset mid-frame
      #2 rst_n = 1'b0;
      #1;
      chk("arst_din",  fifo_din, 32'h0);
      chk("arst_wr",   {31'd0, fifo_wr_en}, 32'd0);
      chk("arst_srst", {31'd0, fifo_srst},  32'd1);
      chk("arst_busy", {31'd0, busy},       32'd0);
      chk("arst_led",  {31'd0, led_run},    32'd0);
      cyc();
      chk("arst_hold_srst", {31'd0, fifo_srst}, 32'd1);
      #2 rst_n = 1'b1;
      #1 chk("arst_rel_srst", {31'd0, fifo_srst}, 32'd1);
      cyc();
      chk("arst_srst_clear", {31'd0, fifo_srst}, 32'd0);
      chk("arst_idle",       {31'd0, busy},      32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/daq_frame_ctrl.md
Name: daq_frame_ctrl

Overview:
- Run controller for the DAQ test-data path: decodes command bytes written by the host into the 8-bit memory window and sequences framed 32-bit words into the 32x512 read FIFO.
- Replaces free-running counter writes with a header/payload/tailer frame machine that honours FIFO backpressure.
- Supports start, graceful close and immediate reset.
- Drives the data-read LED and a status bank that the host reads back.

Parameters:
- WORDS_PER_FRAME, 24, payload words per frame (768 bits / 32); legal range 1..65535
- GAP_CYCLES, 0, idle cycles between frames; 0 = back-to-back
- HDR_BYTE, 8'hF0, header marker
- TLR_BYTE, 8'hAA, tailer marker
- CMD_START, 8'hFF, start command code
- CMD_RESET, 8'hC0, reset command code
- CMD_CLOSE, 8'hC7, close command code

Ports:
- bus_clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle strobe: host wrote memory address 0
- cmd_data  in  8  command byte, valid with cmd_valid
- stream_open  in  1  host has the 32-bit read device open
- fifo_full  in  1  read FIFO full
- fifo_din  out  32  FIFO write data
- fifo_wr_en  out  1  FIFO write enable
- fifo_srst  out  1  FIFO synchronous reset request
- busy  out  1  a frame is in progress
- frame_cnt  out  24  completed frames since last reset
- led_run  out  1  data-read indicator (GPIO_LED_6)

Behaviour:
- Reset (rst_n low, asynchronous) puts every output in a defined state:
  - state = IDLE; fifo_din = 0; fifo_wr_en = 0; busy = 0; frame_cnt = 0; led_run = 0.
  - fifo_srst = 1 while rst_n is low and for 1 cycle after release.
- States:
  - IDLE: nothing written.
  - HDR: emit word {HDR_BYTE, frame_cnt[23:0]}.
  - PAY: emit payload word k (k = 0..WORDS_PER_FRAME-1) = {frame_cnt[15:0], k[15:0]}.
  - TLR: emit word {TLR_BYTE, 8'h00, xor16}, where xor16 = XOR of the low 16 bits of all payload words in the frame.
  - GAP: count GAP_CYCLES, then go to HDR.
- Emission handshake:
  - In HDR, PAY and TLR, fifo_wr_en = !fifo_full. This is the only combinational path from input to output.
  - fifo_din is registered and holds the current word.
  - A word is accepted when fifo_wr_en = 1 on a clock edge. The state/word index advances only on acceptance.
  - While fifo_full = 1, the word is held with no loss or duplication.
- Command decode (only when cmd_valid = 1; codes other than CMD_START/CMD_CLOSE/CMD_RESET are ignored):
  - CMD_START in IDLE with stream_open = 1: go to HDR next cycle, and the first header can be written that cycle (start-to-first-write latency = 1).
  - CMD_START with stream_open = 0: ignored.
  - CMD_START while running: ignored; also clears any pending close.
  - CMD_CLOSE: sets close_pend. The current frame completes through TLR, then the machine goes to IDLE instead of GAP/HDR. CMD_CLOSE in IDLE has no effect.
  - CMD_RESET: immediate abort from any state. Next cycle: IDLE, frame_cnt = 0, close_pend = 0, fifo_srst pulses 1 for 1 cycle. A partial frame is discarded.
- stream_open falling: treated as CMD_RESET, except fifo_srst is not pulsed (the top level already resets the FIFO on close).
- Priority when events coincide: reset / stream close > close > start.
- frame_cnt:
  - Increments on TLR acceptance.
  - Wraps 24'hFFFFFF -> 0.
  - The header carries the pre-increment value.
- busy = 1 in HDR, PAY and TLR.
- led_run = 1 whenever state != IDLE (registered).
- Word index counter is 16 bits and clears on entry to HDR.
- GAP_CYCLES = 0: TLR acceptance goes straight to HDR, giving back-to-back frames.

Test Plan:
1. WORDS_PER_FRAME = 4, GAP_CYCLES = 0, fifo_full = 0, stream_open = 1, CMD_START -> from the next cycle, continuous writes F0000000, 00000000, 00000001, 00000002, 00000003, AA000000 (xor16 = 0^1^2^3 = 0000), F0000001, ...; frame_cnt increments each 6 words.
2. fifo_full held high for 10 cycles mid-payload -> fifo_wr_en = 0 throughout, fifo_din stable, and the sequence resumes with the same word and no gap or duplicate.
3. CMD_CLOSE during payload word 1 -> rest of the frame and the tailer are written, then IDLE; busy and led_run drop the cycle after tailer acceptance; frame_cnt = 1.
4. CMD_RESET during PAY -> next cycle IDLE, fifo_srst high exactly 1 cycle, frame_cnt = 0; a subsequent CMD_START gives header F0000000.
5. stream_open dropped mid-frame -> IDLE, no fifo_srst pulse; CMD_START with stream_open = 0 -> no writes; unknown code 8'h12 -> no state change.
6. rst_n asserted mid-frame, asynchronous to bus_clk -> outputs go to reset values immediately; fifo_srst stays high until 1 cycle after rst_n rises.
